// File: rtl/arith_share_sched.sv
// Shares one arithmetic engine (add/sub/mul in one cycle, restoring divide) between two
// valid/ready requesters. Round-robin arbitration; the result is returned tagged with the requester id.
module arith_share_sched #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_req_valid_0,
  input  logic [1:0]        i_op_0,
  input  logic [DATA_W-1:0] i_value_a_0,
  input  logic [DATA_W-1:0] i_value_b_0,
  output logic              o_req_ready_0,
  input  logic              i_req_valid_1,
  input  logic [1:0]        i_op_1,
  input  logic [DATA_W-1:0] i_value_a_1,
  input  logic [DATA_W-1:0] i_value_b_1,
  output logic              o_req_ready_1,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic              o_rsp_id,
  output logic [DATA_W-1:0] o_result,
  output logic              o_div_by_zero
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic                last_grant_r;
  logic [1:0]          op_r;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic [DATA_W-1:0]   rem_r;
  logic [DATA_W-1:0]   quo_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                rsp_valid_r;
  logic                rsp_id_r;
  logic [DATA_W-1:0]   result_r;
  logic                dbz_r;

  logic                grant_0_s;
  logic                grant_1_s;
  logic                accept_s;
  logic [1:0]          sel_op_s;
  logic [DATA_W-1:0]   sel_a_s;
  logic [DATA_W-1:0]   sel_b_s;
  logic [DATA_W-1:0]   exec_res_s;
  logic                exec_dbz_s;
  logic [DATA_W:0]     shifted_s;
  logic [DATA_W:0]     diff_s;
  logic [DATA_W-1:0]   rem_nxt_s;
  logic                q_bit_s;

  // Arbitration: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant_0_s = 1'b0;
    grant_1_s = 1'b0;
    sel_op_s  = i_op_0;
    sel_a_s   = i_value_a_0;
    sel_b_s   = i_value_b_0;
    if (i_req_valid_0 && (!i_req_valid_1 || last_grant_r)) begin
      grant_0_s = 1'b1;
    end else begin
      grant_0_s = 1'b0;
    end
    if (i_req_valid_1 && (!i_req_valid_0 || !last_grant_r)) begin
      grant_1_s = 1'b1;
    end else begin
      grant_1_s = 1'b0;
    end
    if (grant_1_s) begin
      sel_op_s = i_op_1;
      sel_a_s  = i_value_a_1;
      sel_b_s  = i_value_b_1;
    end else begin
      sel_op_s = i_op_0;
      sel_a_s  = i_value_a_0;
      sel_b_s  = i_value_b_0;
    end
  end

  // Next-state and ready decode; requests are only accepted while idle.
  always_comb begin
    state_nxt_s   = state_r;
    o_req_ready_0 = 1'b0;
    o_req_ready_1 = 1'b0;
    accept_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        o_req_ready_0 = grant_0_s;
        o_req_ready_1 = grant_1_s;
        accept_s      = grant_0_s | grant_1_s;
        if (accept_s) begin
          // A zero divisor skips the iterative path and is resolved in one EXEC cycle.
          if ((sel_op_s == OP_DIV) && (sel_b_s != '0)) begin
            state_nxt_s = ST_DIV;
          end else begin
            state_nxt_s = ST_EXEC;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: state_nxt_s = ST_DONE;
      ST_DIV: begin
        if (cnt_r == DIV_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DIV;
        end
      end
      ST_DONE: begin
        if (rsp_valid_r && i_rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Single-cycle engine result.
  always_comb begin
    exec_res_s = '0;
    exec_dbz_s = (op_r == OP_DIV);
    case (op_r)
      OP_ADD:  exec_res_s = a_r + b_r;
      OP_SUB:  exec_res_s = a_r - b_r;
      OP_MUL:  exec_res_s = a_r * b_r;
      default: exec_res_s = {DATA_W{1'b1}};
    endcase
  end

  // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted_s = {rem_r, quo_r[DATA_W-1]};
    diff_s    = shifted_s - {1'b0, b_r};
    rem_nxt_s = '0;
    q_bit_s   = 1'b0;
    if (diff_s[DATA_W]) begin
      rem_nxt_s = shifted_s[DATA_W-1:0];
      q_bit_s   = 1'b0;
    end else begin
      rem_nxt_s = diff_s[DATA_W-1:0];
      q_bit_s   = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, divider iteration and registered response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_r <= 1'b1;
      op_r         <= 2'b00;
      a_r          <= '0;
      b_r          <= '0;
      rem_r        <= '0;
      quo_r        <= '0;
      cnt_r        <= '0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      result_r     <= '0;
      dbz_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r         <= sel_op_s;
            a_r          <= sel_a_s;
            b_r          <= sel_b_s;
            rsp_id_r     <= grant_1_s;
            last_grant_r <= grant_1_s;
            rem_r        <= '0;
            quo_r        <= sel_a_s;
            cnt_r        <= '0;
          end
        end
        ST_EXEC: begin
          result_r <= exec_res_s;
          dbz_r    <= exec_dbz_s;
        end
        ST_DIV: begin
          // The dividend register shifts out as quotient bits shift in; the extra cycle publishes it.
          if (cnt_r == DIV_LAST) begin
            result_r <= quo_r;
            dbz_r    <= 1'b0;
          end else begin
            rem_r <= rem_nxt_s;
            quo_r <= {quo_r[DATA_W-2:0], q_bit_s};
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (!rsp_valid_r) begin
            rsp_valid_r <= 1'b1;
          end else if (i_rsp_ready) begin
            rsp_valid_r <= 1'b0;
          end
        end
        default: rsp_valid_r <= 1'b0;
      endcase
    end
  end

  assign o_rsp_valid   = rsp_valid_r;
  assign o_rsp_id      = rsp_id_r;
  assign o_result      = result_r;
  assign o_div_by_zero = dbz_r;

endmodule
